// File: rtl/uart_rx.sv
// uart_rx: 8N1/8E1 UART receiver with oversampled 2-of-3 mid-bit voting
// and a valid/ready byte output carrying parity, framing and overrun status.
module uart_rx #(
  parameter int PARITY_EN = 0,
  parameter int OS_RATE   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_os_stb,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       rx_busy
);

  localparam int OW = $clog2(OS_RATE);
  localparam logic [OW-1:0] S0 = OW'(OS_RATE/2-1);
  localparam logic [OW-1:0] S1 = OW'(OS_RATE/2);
  localparam logic [OW-1:0] VP = OW'(OS_RATE/2+1);
  localparam logic [OW-1:0] BE = OW'(OS_RATE-1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic [OW-1:0] os_cnt, os_n;
  logic [2:0]    bit_cnt, bit_n;
  logic          s1, rxd_s;
  logic          v0, v1, voted;
  logic [7:0]    shift;
  logic          perr;
  logic          at_vp, at_end;
  logic          shift_en, perr_en, clr_err, done;
  logic          load, drop;

  assign at_vp   = os_cnt == VP;
  assign at_end  = os_cnt == BE;
  assign voted   = (v0 & v1) | (v0 & rxd_s) | (v1 & rxd_s);
  assign load    = done & (~dout_valid | dout_ready);
  assign drop    = done & dout_valid & ~dout_ready;
  assign rx_busy = state != IDLE;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    os_n     = os_cnt;
    bit_n    = bit_cnt;
    shift_en = 1'b0;
    perr_en  = 1'b0;
    clr_err  = 1'b0;
    done     = 1'b0;
    if (rx_os_stb) begin
      os_n = at_end ? '0 : os_cnt + 1'b1;
      unique case (state)
        // detection strobe is tick 0 of the start bit
        IDLE: begin
          if (!rxd_s) begin
            state_n = START;
            clr_err = 1'b1;
          end else begin
            os_n = '0;
          end
        end
        START: begin
          if (at_vp && voted) begin
            state_n = IDLE;
            os_n    = '0;
          end else if (at_end) begin
            state_n = DATA;
            bit_n   = '0;
          end
        end
        DATA: begin
          shift_en = at_vp;
          if (at_end) begin
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          perr_en = at_vp;
          if (at_end) state_n = STOP;
        end
        // frame ends at the stop vote so a new start edge is not missed
        STOP: begin
          if (at_vp) begin
            done    = 1'b1;
            os_n    = '0;
            state_n = voted ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          os_n = '0;
          if (rxd_s) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          os_n    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt     <= '0;
      bit_cnt    <= '0;
      s1         <= 1'b1;
      rxd_s      <= 1'b1;
      v0         <= 1'b1;
      v1         <= 1'b1;
      shift      <= '0;
      perr       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      s1      <= rxd;
      rxd_s   <= s1;
      os_cnt  <= os_n;
      bit_cnt <= bit_n;
      if (rx_os_stb && os_cnt == S0) v0 <= rxd_s;
      if (rx_os_stb && os_cnt == S1) v1 <= rxd_s;
      if (shift_en) shift[bit_cnt] <= voted;
      if (clr_err)      perr <= 1'b0;
      else if (perr_en) perr <= voted ^ (^shift);
      if (load) begin
        dout       <= shift;
        parity_err <= perr;
        frame_err  <= ~voted;
      end
      if (load)            dout_valid <= 1'b1;
      else if (dout_ready) dout_valid <= 1'b0;
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: vector table, directed corner sequences and random frames
// checked against a frame-level model of an 8N1 / 8E1 receiver.
module tb_uart_rx;

  localparam int BC = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_os_stb = 1'b0;
  logic rxd = 1'b1;
  logic dout_ready = 1'b1;
  logic overrun_clr = 1'b0;

  logic [7:0] dout [2];
  logic dout_valid [2];
  logic parity_err [2];
  logic frame_err [2];
  logic overrun [2];
  logic rx_busy [2];

  int errors = 0;
  int checks = 0;
  logic [9:0] got0 [$];
  logic [9:0] got1 [$];
  int vcnt [2];
  int bcnt [2];
  logic ts1 = 1'b1;
  logic ts2 = 1'b1;

  typedef struct {
    logic [7:0] d;
    int         t;
    logic       pb;
    logic       sb;
    int         bc;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  uart_rx #(.PARITY_EN(0), .OS_RATE(16)) u0 (
    .clk(clk), .rst(rst), .rx_os_stb(rx_os_stb), .rxd(rxd),
    .dout(dout[0]), .dout_valid(dout_valid[0]),
    .dout_ready(dout_ready), .parity_err(parity_err[0]),
    .frame_err(frame_err[0]), .overrun(overrun[0]),
    .overrun_clr(overrun_clr), .rx_busy(rx_busy[0])
  );

  uart_rx #(.PARITY_EN(1), .OS_RATE(16)) u1 (
    .clk(clk), .rst(rst), .rx_os_stb(rx_os_stb), .rxd(rxd),
    .dout(dout[1]), .dout_valid(dout_valid[1]),
    .dout_ready(dout_ready), .parity_err(parity_err[1]),
    .frame_err(frame_err[1]), .overrun(overrun[1]),
    .overrun_clr(overrun_clr), .rx_busy(rx_busy[1])
  );

  always #5 clk = ~clk;

  initial begin
    bit ph;
    ph = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = ~ph;
      rx_os_stb = ph;
    end
  end

  always @(posedge clk) begin
    ts1 <= rxd;
    ts2 <= ts1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid[0] && dout_ready)
        got0.push_back({parity_err[0], frame_err[0], dout[0]});
      if (dout_valid[1] && dout_ready)
        got1.push_back({parity_err[1], frame_err[1], dout[1]});
    end
    for (int i = 0; i < 2; i++) begin
      if (dout_valid[i]) vcnt[i]++;
      if (rx_os_stb && rx_busy[i]) bcnt[i]++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int gsz(input int t);
    return (t == 1) ? got1.size() : got0.size();
  endfunction

  function automatic logic [9:0] nth(input int t, input int i);
    return (t == 1) ? got1[i] : got0[i];
  endfunction

  task automatic bitw(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic gap(input int bits);
    repeat (bits * BC) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input int t, input logic pb,
                      input logic sb, input int bc);
    bitw(1'b0, bc);
    for (int i = 0; i < 8; i++) bitw(d[i], bc);
    if (t == 1) bitw(pb, bc);
    bitw(sb, bc);
    rxd = 1'b1;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] d,
                           input int t, input logic pb, input logic sb,
                           input int bc, input logic [7:0] ed,
                           input logic ep, input logic ef);
    int base, vb;
    logic [9:0] b;
    base = gsz(t);
    vb = vcnt[t];
    send(d, t, pb, sb, bc);
    gap(12);
    @(negedge clk);
    chk({nm, " count"}, 32'(gsz(t) - base), 32'd1);
    b = nth(t, base);
    chk({nm, " dout"}, 32'(b[7:0]), 32'(ed));
    chk({nm, " parity_err"}, 32'(b[9]), 32'(ep));
    chk({nm, " frame_err"}, 32'(b[8]), 32'(ef));
    chk({nm, " valid_cycles"}, 32'(vcnt[t] - vb), 32'd1);
    chk({nm, " busy_after"}, 32'(rx_busy[t]), 32'd0);
    chk({nm, " overrun"}, 32'(overrun[t]), 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    int b0, b1, v0s, v1s;
    tbl[0] = '{8'hA5, 0, 1'b0, 1'b1, BC,     8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 1, 1'b0, 1'b1, BC,     8'h03, 1'b0, 1'b0};
    tbl[2] = '{8'h07, 1, 1'b0, 1'b1, BC,     8'h07, 1'b1, 1'b0};
    tbl[3] = '{8'h5A, 0, 1'b0, 1'b1, BC + 1, 8'h5A, 1'b0, 1'b0};
    tbl[4] = '{8'h5A, 0, 1'b0, 1'b1, BC - 1, 8'h5A, 1'b0, 1'b0};
    tbl[5] = '{8'hC3, 0, 1'b0, 1'b0, BC,     8'hC3, 1'b0, 1'b1};
    tbl[6] = '{8'h96, 1, 1'b1, 1'b1, BC,     8'h96, 1'b1, 1'b0};
    tbl[7] = '{8'h00, 1, 1'b0, 1'b0, BC,     8'h00, 1'b0, 1'b1};
    tbl[8] = '{8'hFF, 0, 1'b0, 1'b1, BC,     8'hFF, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst dout", 32'(dout[0]), 32'd0);
    chk("rst valid", 32'(dout_valid[0]), 32'd0);
    chk("rst parity_err", 32'(parity_err[0]), 32'd0);
    chk("rst frame_err", 32'(frame_err[0]), 32'd0);
    chk("rst overrun", 32'(overrun[0]), 32'd0);
    chk("rst busy", 32'(rx_busy[0]), 32'd0);
    chk("rst busy p", 32'(rx_busy[1]), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    gap(2);

    for (int i = 0; i < 9; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].t, tbl[i].pb,
                tbl[i].sb, tbl[i].bc, tbl[i].ed, tbl[i].ep, tbl[i].ef);

    b0 = bcnt[0];
    b1 = bcnt[1];
    v0s = vcnt[0];
    rxd = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rxd = 1'b1;
    gap(2);
    @(negedge clk);
    chk("false start ticks", 32'(bcnt[0] - b0), 32'd9);
    chk("false start ticks p", 32'(bcnt[1] - b1), 32'd9);
    chk("false start valid", 32'(vcnt[0] - v0s), 32'd0);
    @(posedge clk);
    #2;
    run_frame("after false", 8'h3C, 0, 1'b0, 1'b1, BC,
              8'h3C, 1'b0, 1'b0);

    b0 = got0.size();
    b1 = got1.size();
    rxd = 1'b0;
    repeat (30 * BC) @(posedge clk);
    @(negedge clk);
    chk("break busy", 32'(rx_busy[0]), 32'd1);
    chk("break busy p", 32'(rx_busy[1]), 32'd1);
    @(posedge clk);
    #2;
    rxd = 1'b1;
    gap(3);
    @(negedge clk);
    chk("break busy end", 32'(rx_busy[0]), 32'd0);
    chk("break count", 32'(got0.size() - b0), 32'd1);
    chk("break byte", 32'(got0[b0]), 32'h100);
    chk("break count p", 32'(got1.size() - b1), 32'd1);
    chk("break byte p", 32'(got1[b1]), 32'h100);
    @(posedge clk);
    #2;

    dout_ready = 1'b0;
    send(8'h11, 0, 1'b0, 1'b1, BC);
    gap(3);
    send(8'h22, 0, 1'b0, 1'b1, BC);
    gap(3);
    @(negedge clk);
    chk("ovr dout held", 32'(dout[0]), 32'h11);
    chk("ovr valid", 32'(dout_valid[0]), 32'd1);
    chk("ovr flag", 32'(overrun[0]), 32'd1);
    @(posedge clk);
    #2;
    dout_ready = 1'b1;
    @(posedge clk);
    #2;
    dout_ready = 1'b0;
    @(negedge clk);
    chk("ovr consumed valid", 32'(dout_valid[0]), 32'd0);
    chk("ovr consumed byte", 32'(got0[got0.size() - 1]), 32'h011);
    chk("ovr sticky", 32'(overrun[0]), 32'd1);
    @(posedge clk);
    #2;
    overrun_clr = 1'b1;
    @(posedge clk);
    #2;
    overrun_clr = 1'b0;
    @(negedge clk);
    chk("ovr cleared", 32'(overrun[0]), 32'd0);
    @(posedge clk);
    #2;

    send(8'h33, 0, 1'b0, 1'b1, BC);
    gap(3);
    @(negedge clk);
    chk("same pend", 32'(dout[0]), 32'h33);
    @(posedge clk);
    #2;
    fork
      send(8'h44, 0, 1'b0, 1'b1, BC);
      begin : ctl
        int n;
        bit hit;
        n = -1;
        hit = 1'b0;
        for (int c = 0; c < 1200 && !hit; c++) begin
          @(posedge clk);
          #3;
          if (rx_os_stb) begin
            if (n < 0) begin
              if (!ts2) n = 0;
            end else begin
              n++;
              if (n == 153) begin
                dout_ready = 1'b1;
                @(posedge clk);
                #3;
                dout_ready = 1'b0;
                hit = 1'b1;
              end
            end
          end
        end
        chk("same window", 32'(hit), 32'd1);
      end
    join
    gap(2);
    @(negedge clk);
    chk("same valid", 32'(dout_valid[0]), 32'd1);
    chk("same dout", 32'(dout[0]), 32'h44);
    chk("same no overrun", 32'(overrun[0]), 32'd0);
    chk("same old taken", 32'(got0[got0.size() - 1]), 32'h033);
    @(posedge clk);
    #2;
    dout_ready = 1'b1;
    gap(1);
    @(negedge clk);
    chk("same new taken", 32'(got0[got0.size() - 1]), 32'h044);
    @(posedge clk);
    #2;

    b0 = got0.size();
    fork
      send(8'h5A, 0, 1'b0, 1'b1, BC);
      begin
        repeat (4 * BC + BC / 2) @(posedge clk);
        @(negedge clk);
        chk("mid busy", 32'(rx_busy[0]), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid rst dout", 32'(dout[0]), 32'd0);
        chk("mid rst valid", 32'(dout_valid[0]), 32'd0);
        chk("mid rst perr", 32'(parity_err[0]), 32'd0);
        chk("mid rst ferr", 32'(frame_err[0]), 32'd0);
        chk("mid rst overrun", 32'(overrun[0]), 32'd0);
        chk("mid rst busy", 32'(rx_busy[0]), 32'd0);
        chk("mid rst busy p", 32'(rx_busy[1]), 32'd0);
      end
    join
    @(posedge clk);
    #2;
    rst = 1'b0;
    gap(2);
    @(negedge clk);
    chk("mid no partial", 32'(got0.size() - b0), 32'd0);
    @(posedge clk);
    #2;
    run_frame("post rst", 8'h5A, 0, 1'b0, 1'b1, BC, 8'h5A, 1'b0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      logic [7:0] d;
      int t, bc;
      logic pb, sb;
      d  = 8'($urandom);
      t  = int'($urandom_range(1, 0));
      pb = 1'($urandom_range(1, 0));
      sb = ($urandom_range(4, 0) != 0);
      bc = BC - 1 + int'($urandom_range(2, 0));
      run_frame($sformatf("rand%0d", r), d, t, pb, sb, bc, d,
                (t == 1) ? (pb ^ (^d)) : 1'b0, ~sb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the transmitter in the same UART block.
- Deserialises an 8N1 frame from rxd, or 8E1 when parity is enabled, using a 16x oversample strobe from the shared baud generator.
- Majority-votes each bit at mid-period.
- Presents each byte on a valid/ready output with per-byte parity and framing error flags and a sticky overrun flag.

Parameters:
- PARITY_EN, 0: 1 = expect an even-parity bit between data and stop.
- OS_RATE, 16: oversample ticks per bit. Legal values are even, 8..32.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- rx_os_stb  input  1  one-clk pulse at OS_RATE x baud
- rxd  input  1  asynchronous serial line, idle high
- dout  output  8  received byte, LSB first on line
- dout_valid  output  1  byte available
- dout_ready  input  1  consumer accepts byte when high with dout_valid
- parity_err  output  1  parity mismatch for the byte on dout
- frame_err  output  1  stop bit sampled 0 for the byte on dout
- overrun  output  1  sticky: a completed frame was dropped
- overrun_clr  input  1  clears overrun
- rx_busy  output  1  high when FSM is not in IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset, any time including mid-frame:
  - dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, rx_busy=0.
  - FSM=IDLE, counters=0, synchroniser flops=1.
  - No partial byte is ever delivered.
- Synchronisation: rxd passes through a 2-flop synchroniser (rxd_s), giving 2 clk latency. All decisions use rxd_s.
- Gating: FSM, os_cnt (width clog2(OS_RATE)) and bit_cnt (3 bits) advance only on cycles with rx_os_stb=1. The output handshake runs every clk.
- Vote points within each bit: rxd_s is sampled at os_cnt = OS_RATE/2-1, OS_RATE/2 and OS_RATE/2+1. The voted bit is the 2-of-3 majority, valid at os_cnt = OS_RATE/2+1 (the vote point).
- A bit period ends at os_cnt = OS_RATE-1; os_cnt then wraps to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on a strobe with rxd_s=0, go to START with os_cnt=0 (the detection tick counts as tick 0).
  - START: at the vote point, voted=1 means a false start and returns to IDLE. Otherwise, at bit end go to DATA with bit_cnt=0.
  - DATA: at the vote point, shift the voted bit into shift[bit_cnt] (LSB first). At bit end, bit_cnt increments. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: at the vote point, perr = voted XOR (^shift) (even parity). At bit end, go to STOP.
  - STOP: at the vote point the frame completes; no waiting for bit end. If voted=1, go to IDLE. If voted=0, set ferr and go to WAIT_HIGH.
  - WAIT_HIGH: stays until a strobe sees rxd_s=1, then goes to IDLE. A line held low (break) therefore yields exactly one frame_err byte.
- Frame completion, on the STOP vote strobe:
  - If dout_valid=0, or dout_valid&dout_ready in the same cycle: load dout=shift, parity_err=perr, frame_err=ferr. dout_valid is 1 from the next clk.
  - Otherwise: the new frame is dropped, overrun is set, and the old dout and flags are held.
- Handshake:
  - dout, parity_err and frame_err are stable while dout_valid=1.
  - A transfer occurs when dout_valid&dout_ready; dout_valid falls the next clk unless a new frame loads in that same cycle.
  - parity_err and frame_err keep their values after the transfer until the next load.
- overrun:
  - Set on a drop and held until overrun_clr or rst.
  - Set and clear in the same cycle: set wins.
- perr and ferr are cleared on entry to START.
- Delivered data is valid even when parity_err or frame_err is set.
- Latency: dout_valid rises 1 clk after the STOP vote strobe, about OS_RATE/2+2 ticks into the stop bit.
- Back-to-back frames: a start edge arriving right after the stop bit is detected normally, because the FSM returns to IDLE mid-stop-bit.

Test Plan:
1. Basic receive: PARITY_EN=0, OS_RATE=16, dout_ready=1, send 0xA5 at nominal baud.
   -> dout=0xA5, dout_valid high for exactly 1 clk, parity_err=0, frame_err=0, overrun=0, rx_busy=0 afterwards.
2. False start: rxd low for 4 strobes then high.
   -> return to IDLE at tick 9, no dout_valid. A following 0x3C frame is received correctly.
3. Parity: PARITY_EN=1, send 0x03 with parity bit 0.
   -> dout=0x03, parity_err=0.
   Send 0x07 with parity bit 0.
   -> dout=0x07, parity_err=1.
4. Break: hold rxd low for 3 frame times.
   -> one byte dout=0x00 with frame_err=1, rx_busy high until rxd returns high, no further bytes.
5. Overrun: dout_ready=0, send 0x11 then 0x22.
   -> dout=0x11 held, overrun=1.
   Pulse dout_ready.
   -> 0x11 consumed, dout_valid=0.
   Pulse overrun_clr.
   -> overrun=0.
   Same-cycle accept at completion.
   -> new byte loaded, no overrun.
6. Reset mid-frame: assert rst after 3 data bits.
   -> all outputs at reset values next clk.
   Release rst and send 0x5A, also with baud skewed ±3%.
   -> dout=0x5A, no error flags.
